vsync_sequencer: RTL and testbench

//  Sequences the 256x4 vertical-timing PROM: owns the 8-bit line counter that addresses it and

---
 rtl/vsync_pkg.sv | 13 +
 rtl/vline_counter.sv | 57 +++++
 rtl/vsync_sequencer.sv | 69 ++++++
 tb/tb_vsync_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vsync_pkg.sv
// Shared definitions for the vertical sequencer: PROM nibble bit positions and line width.
package vsync_pkg;

    localparam int LINE_W   = 8;

    localparam int VS_BIT   = 0;
    localparam int AUX_BIT  = 1;
    localparam int VRST_BIT = 2;
    localparam int VBL_BIT  = 3;

    typedef logic [3:0] vstate_t;

endpackage

// File: rtl/vline_counter.sv
// Line counter addressing the vertical PROM; reloads on a VRESET line.
// Optional watchdog (macro VSEQ_WATCHDOG_EN) forces a reload when VRESET never arrives.
module vline_counter
    import vsync_pkg::*;
#(
    parameter logic [LINE_W-1:0] LOAD_VAL  = 8'h00,
    parameter logic [8:0]        MAX_LINES = 9'd300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_stb,
    input  logic              vrst,
    output logic [LINE_W-1:0] line,
    output logic              wd_err
);

`ifdef VSEQ_WATCHDOG_EN
    logic [8:0] wd_cnt;
    logic       wd_hit;

    // The strobe that would bring the count up to MAX_LINES is the one that trips
    assign wd_hit = (wd_cnt == MAX_LINES - 9'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            line   <= '0;
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (line_stb) begin
            if (vrst) begin
                line   <= LOAD_VAL;
                wd_cnt <= '0;
            end else if (wd_hit) begin
                line   <= LOAD_VAL;
                wd_cnt <= '0;
                wd_err <= 1'b1;
            end else begin
                line   <= line + 1'b1;
                wd_cnt <= wd_cnt + 9'd1;
            end
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^MAX_LINES;
    assign wd_err       = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            line <= '0;
        end else if (line_stb) begin
            line <= vrst ? LOAD_VAL : line + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/vsync_sequencer.sv
// Vertical timing sequencer: latches the PROM nibble per scan line, counts frames and raises
// a CPU IRQ on selected lines. Watchdog available with macro VSEQ_WATCHDOG_EN.
module vsync_sequencer
    import vsync_pkg::*;
#(
    parameter logic [LINE_W-1:0] LOAD_VAL  = 8'h00,
    parameter logic [LINE_W-1:0] IRQ_MASK  = 8'h3f,
    parameter logic [LINE_W-1:0] IRQ_MATCH = 8'h3f,
    parameter logic [8:0]        MAX_LINES = 9'd300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_stb,
    output logic [LINE_W-1:0] prom_a,
    input  logic [3:0]        prom_d,
    output logic              vsync,
    output logic              vblank,
    output logic              vaux,
    output logic              vblank_rise,
    output logic [7:0]        frame_cnt,
    output logic              irq,
    input  logic              irq_ack,
    output logic              wd_err
);

    vstate_t d;
    logic    irq_hit;
    logic    rise_now;

    assign d        = prom_d;
    assign irq_hit  = ((prom_a & IRQ_MASK) == IRQ_MATCH);
    assign rise_now = line_stb & d[VBL_BIT] & ~vblank;

    vline_counter #(
        .LOAD_VAL  (LOAD_VAL),
        .MAX_LINES (MAX_LINES)
    ) u_line (
        .clk      (clk),
        .reset    (reset),
        .line_stb (line_stb),
        .vrst     (d[VRST_BIT]),
        .line     (prom_a),
        .wd_err   (wd_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync       <= 1'b0;
            vblank      <= 1'b0;
            vaux        <= 1'b0;
            vblank_rise <= 1'b0;
            frame_cnt   <= '0;
            irq         <= 1'b0;
        end else begin
            if (line_stb) begin
                vsync  <= d[VS_BIT];
                vaux   <= d[AUX_BIT];
                vblank <= d[VBL_BIT];
            end
            vblank_rise <= rise_now;
            if (rise_now) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A new request outranks an acknowledge landing in the same cycle
            irq <= (line_stb & irq_hit) | (irq & ~irq_ack);
        end
    end

endmodule

// File: tb/tb_vsync_sequencer.sv
// Self-checking bench for vsync_sequencer: PROM model, reference model + scoreboard,
// table-driven IRQ vectors and hand-written multi-cycle sequences.
module tb_vsync_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line_stb = 1'b0;
    logic       irq_ack = 1'b0;
    logic [7:0] prom_a;
    logic [3:0] prom_d;
    logic       vsync, vblank, vaux, vblank_rise, irq, wd_err;
    logic [7:0] frame_cnt;

    int mode = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    vsync_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .line_stb    (line_stb),
        .prom_a      (prom_a),
        .prom_d      (prom_d),
        .vsync       (vsync),
        .vblank      (vblank),
        .vaux        (vaux),
        .vblank_rise (vblank_rise),
        .frame_cnt   (frame_cnt),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .wd_err      (wd_err)
    );

    // PROM contents {VBLANK, VRESET, AUX, VSYNC} for the three test images
    function automatic logic [3:0] prom_fn(input int m, input logic [7:0] a);
        logic [3:0] r;
        r = 4'b0000;
        case (m)
            0: begin
                r[0] = (a >= 8'h03) && (a <= 8'h05);
                r[1] = a[4];
                r[2] = (a == 8'h85);
                r[3] = (a >= 8'h78);
            end
            1: begin
                r[0] = (a >= 8'h82) && (a <= 8'h84);
                r[1] = a[5];
                r[3] = (a >= 8'h80);
            end
            default: begin
                r[0] = a[1];
                r[3] = a[0];
            end
        endcase
        return r;
    endfunction

    always_comb prom_d = prom_fn(mode, prom_a);

    typedef struct {
        logic [7:0] line;
        logic       vs;
        logic       vb;
        logic       aux;
        logic       rise;
        logic [7:0] frame;
        logic       irq;
        logic       wd;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_line = 8'h00;
    logic       m_vs = 1'b0, m_vb = 1'b0, m_aux = 1'b0, m_rise = 1'b0, m_irq = 1'b0, m_wd = 1'b0;
    logic [7:0] m_frame = 8'h00;
    logic [8:0] m_wdc = 9'd0;

    task automatic modelStep(input logic stb, input logic ack, input logic rst);
        logic [3:0] d;
        if (rst) begin
            m_line = 8'h00; m_vs = 0; m_vb = 0; m_aux = 0; m_rise = 0;
            m_frame = 8'h00; m_irq = 0; m_wd = 0; m_wdc = 9'd0;
        end else begin
            m_rise = 1'b0;
            if (stb) begin
                d = prom_fn(mode, m_line);
                if (d[3] && !m_vb) begin
                    m_rise  = 1'b1;
                    m_frame = m_frame + 8'd1;
                end
                m_vs = d[0]; m_aux = d[1]; m_vb = d[3];
                if ((m_line & 8'h3f) == 8'h3f) m_irq = 1'b1;
                else if (ack) m_irq = 1'b0;
`ifdef VSEQ_WATCHDOG_EN
                if (d[2]) begin
                    m_line = 8'h00; m_wdc = 9'd0;
                end else if (m_wdc == 9'd299) begin
                    m_line = 8'h00; m_wdc = 9'd0; m_wd = 1'b1;
                end else begin
                    m_line = m_line + 8'd1; m_wdc = m_wdc + 9'd1;
                end
`else
                m_line = d[2] ? 8'h00 : m_line + 8'd1;
`endif
            end else if (ack) begin
                m_irq = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        chk_cnt++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard: got empty queue, required one entry");
            return;
        end
        e = sb.pop_front();
        if ({prom_a, vsync, vblank, vaux, vblank_rise, frame_cnt, irq, wd_err} !==
            {e.line, e.vs, e.vb, e.aux, e.rise, e.frame, e.irq, e.wd}) begin
            $display("[TB] FAIL model @%0t: got line=%h vs=%b vb=%b aux=%b rise=%b frame=%h irq=%b wd=%b, required line=%h vs=%b vb=%b aux=%b rise=%b frame=%h irq=%b wd=%b",
                     $time, prom_a, vsync, vblank, vaux, vblank_rise, frame_cnt, irq, wd_err,
                     e.line, e.vs, e.vb, e.aux, e.rise, e.frame, e.irq, e.wd);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic handCheck(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act !== req) $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        else pass_cnt++;
    endtask

    task automatic applyStimulus(input logic stb, input logic ack, input logic rst);
        exp_t e;
        line_stb = stb;
        irq_ack  = ack;
        reset    = rst;
        modelStep(stb, ack, rst);
        e.line = m_line; e.vs = m_vs; e.vb = m_vb; e.aux = m_aux; e.rise = m_rise;
        e.frame = m_frame; e.irq = m_irq; e.wd = m_wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        line_stb = 1'b0;
        irq_ack  = 1'b0;
        reset    = 1'b0;
        checkOutput();
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        int         pre;
        logic       stb;
        logic       ack;
        logic [7:0] exp_line;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'h3e, 1'b1, 1'b0, 8'h3f, 1'b0};
        vecs[1]  = '{0,      1'b1, 1'b0, 8'h40, 1'b1};
        vecs[2]  = '{0,      1'b0, 1'b0, 8'h40, 1'b1};
        vecs[3]  = '{0,      1'b0, 1'b0, 8'h40, 1'b1};
        vecs[4]  = '{0,      1'b0, 1'b0, 8'h40, 1'b1};
        vecs[5]  = '{0,      1'b0, 1'b0, 8'h40, 1'b1};
        vecs[6]  = '{0,      1'b0, 1'b1, 8'h40, 1'b0};
        vecs[7]  = '{0,      1'b0, 1'b1, 8'h40, 1'b0};
        vecs[8]  = '{32'h3e, 1'b1, 1'b0, 8'h7f, 1'b0};
        vecs[9]  = '{0,      1'b1, 1'b1, 8'h80, 1'b1};
        vecs[10] = '{0,      1'b0, 1'b0, 8'h80, 1'b1};
        vecs[11] = '{32'h3e, 1'b1, 1'b0, 8'hbf, 1'b1};
        vecs[12] = '{0,      1'b1, 1'b1, 8'hc0, 1'b1};
        vecs[13] = '{0,      1'b0, 1'b1, 8'hc0, 1'b0};

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        handCheck("reset_line", prom_a, 8'h00);
        handCheck("reset_outs", {vsync, vblank, vaux, vblank_rise, irq, wd_err}, 6'b0);
        handCheck("reset_frame", frame_cnt, 8'h00);

        // VRESET at line 0x85: period of 134 lines
        mode = 0;
        for (int k = 1; k <= 300; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (k % 50 == 0 || k == 134 || k == 135) handCheck("period_line", prom_a, k % 134);
        end
        handCheck("period_frames", frame_cnt, 8'd2);

        // IRQ vectors from table
        $display("[TB] irq vector table");
        mode = 1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            strobes(vecs[i].pre);
            applyStimulus(vecs[i].stb, vecs[i].ack, 1'b0);
            handCheck($sformatf("vec%0d_line", i), prom_a, vecs[i].exp_line);
            handCheck($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
        end

        // Hold with no strobe at line 0x40
        applyStimulus(1'b0, 1'b0, 1'b1);
        strobes(8'h40);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        handCheck("hold_line", prom_a, 8'h40);
        handCheck("hold_outs", {vsync, vblank, vaux, irq}, 4'b0011);

        // Reset mid-frame with irq pending, counter 0x90, vblank high
        applyStimulus(1'b0, 1'b0, 1'b1);
        strobes(8'h90);
        handCheck("pre_reset_state", {prom_a, vblank, irq}, {8'h90, 1'b1, 1'b1});
        applyStimulus(1'b1, 1'b0, 1'b1);
        handCheck("mid_reset_state", {prom_a, vsync, vblank, vaux, vblank_rise, irq, frame_cnt},
                  {8'h00, 5'b0, 1'b0, 8'h00});

        // Counter wrap and frame counter wrap
        mode = 2;
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 512; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (k == 255) handCheck("wrap_ff", prom_a, 8'hff);
            if (k == 256) handCheck("wrap_00", prom_a, 8'h00);
            if (k == 510) handCheck("frame_ff", frame_cnt, 8'hff);
            if (k == 512) handCheck("frame_00", frame_cnt, 8'h00);
        end

        // Watchdog: PROM never asserts VRESET
        mode = 1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        strobes(299);
        handCheck("wd_299_line", prom_a, 8'h2b);
        handCheck("wd_299_err", wd_err, 1'b0);
        strobes(1);
`ifdef VSEQ_WATCHDOG_EN
        handCheck("wd_300_line", prom_a, 8'h00);
        handCheck("wd_300_err", wd_err, 1'b1);
        strobes(20);
        handCheck("wd_sticky", wd_err, 1'b1);
`else
        handCheck("wd_300_line", prom_a, 8'h2c);
        handCheck("wd_300_err", wd_err, 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b1);
        handCheck("wd_reset", wd_err, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
